// File: rtl/dm_pkg.sv
// Shared size codes and FSM state encodings for the byte-lane data memory dm_be.
package dm_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_IDLE  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } dm_state_t;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic for dm_be: byte enables, store merge, load extension
// and alignment check for one request against the currently addressed word.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_sext,
  input  logic [31:0] i_din,
  input  logic [31:0] i_old,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_misalign
);

  logic [3:0]  w_be_raw;
  logic [31:0] w_rep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store data is replicated across lanes so the enables alone select placement.
  always_comb begin
    w_byte     = i_old[{i_lane, 3'b000} +: 8];
    w_half     = i_lane[1] ? i_old[31:16] : i_old[15:0];
    w_be_raw   = 4'b0000;
    w_rep      = i_din;
    o_ldata    = i_old;
    o_misalign = 1'b0;
    case (i_size)
      SZ_B: begin
        w_be_raw = 4'b0001 << i_lane;
        w_rep    = {4{i_din[7:0]}};
        o_ldata  = {{24{i_sext & w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_misalign = i_lane[0];
        w_be_raw   = i_lane[1] ? 4'b1100 : 4'b0011;
        w_rep      = {2{i_din[15:0]}};
        o_ldata    = {{16{i_sext & w_half[15]}}, w_half};
      end
      SZ_W: begin
        o_misalign = (i_lane != 2'b00);
        w_be_raw   = 4'b1111;
      end
      default: begin
        o_misalign = 1'b1;
        w_be_raw   = 4'b0000;
      end
    endcase
    if (o_misalign) begin
      o_be = 4'b0000;
    end else begin
      o_be = w_be_raw;
    end
  end

  // Untouched lanes keep the old word contents.
  always_comb begin
    o_wdata = i_old;
    for (int k = 0; k < 4; k++) begin
      if (o_be[k]) begin
        o_wdata[8*k +: 8] = w_rep[8*k +: 8];
      end else begin
        o_wdata[8*k +: 8] = i_old[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_be.sv
// Byte-lane data memory with wait states, req/ready handshake and post-reset clear.
// Optional store trace is enabled by defining DM_TRACE_EN.
module dm_be
  import dm_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [31:0] pc,
  output logic        ready,
  output logic [31:0] dout,
  output logic        align_err,
  output logic        busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  dm_state_t   r_state;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]  r_cnt;
  logic        r_ready, r_align_err, r_busy;
  logic [31:0] r_dout;
  logic        r_we, r_sext;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_din;
  logic [31:0] r_mem [DEPTH];

  logic        w_cur_we, w_cur_sext;
  logic [1:0]  w_cur_size;
  logic [31:0] w_cur_addr, w_cur_din;
  logic [IDX_W-1:0] w_idx;
  logic [31:0] w_old, w_merged, w_ldata;
  logic [3:0]  w_be;
  logic        w_misalign, w_enter_done, w_store, w_clear_we;

  // With no wait states DONE is entered on the accept edge, so the live inputs are used.
  assign w_cur_we   = (r_state == ST_IDLE) ? we   : r_we;
  assign w_cur_sext = (r_state == ST_IDLE) ? sext : r_sext;
  assign w_cur_size = (r_state == ST_IDLE) ? size : r_size;
  assign w_cur_addr = (r_state == ST_IDLE) ? addr : r_addr;
  assign w_cur_din  = (r_state == ST_IDLE) ? din  : r_din;
  assign w_idx      = w_cur_addr[ADDR_W-1:2];
  assign w_old      = r_mem[w_idx];

  assign w_enter_done = ((r_state == ST_IDLE) && req && (WAIT_CYC == 0)) ||
                        ((r_state == ST_WAIT) && (r_cnt == 4'd0));
  assign w_store      = w_enter_done && w_cur_we && !w_misalign && !reset;
  assign w_clear_we   = (r_state == ST_CLEAR) && !reset;

  dm_lane_align u_align (
    .i_size     (w_cur_size),
    .i_lane     (w_cur_addr[1:0]),
    .i_sext     (w_cur_sext),
    .i_din      (w_cur_din),
    .i_old      (w_old),
    .o_be       (w_be),
    .o_wdata    (w_merged),
    .o_ldata    (w_ldata),
    .o_misalign (w_misalign)
  );

  // Control FSM with capture registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_idx       <= '0;
      r_cnt       <= 4'd0;
      r_ready     <= 1'b0;
      r_align_err <= 1'b0;
      r_dout      <= 32'h0;
      r_busy      <= 1'b1;
      r_we        <= 1'b0;
      r_sext      <= 1'b0;
      r_size      <= SZ_B;
      r_addr      <= 32'h0;
      r_din       <= 32'h0;
    end else begin
      r_ready     <= 1'b0;
      r_align_err <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (req) begin
            r_we   <= we;
            r_sext <= sext;
            r_size <= size;
            r_addr <= addr;
            r_din  <= din;
            r_busy <= 1'b1;
            if (WAIT_CYC > 0) begin
              r_state <= ST_WAIT;
              r_cnt   <= 4'(WAIT_CYC - 1);
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_idx   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
      if (w_enter_done) begin
        r_ready     <= 1'b1;
        r_align_err <= w_misalign;
        if (!w_cur_we && !w_misalign) begin
          r_dout <= w_ldata;
        end
      end
    end
  end

  // Single write port: clear sweep or committed store, never both.
  always_ff @(posedge clk) begin
    if (w_clear_we) begin
      r_mem[r_idx] <= 32'h0;
    end else if (w_store) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign ready     = r_ready;
  assign dout      = r_dout;
  assign align_err = r_align_err;
  assign busy      = r_busy;

`ifdef DM_TRACE_EN
  logic [31:0] r_pc;
  logic [31:0] w_cur_pc;
  assign w_cur_pc = (r_state == ST_IDLE) ? pc : r_pc;

  // PC of the accepted request, kept for the trace line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= 32'h0;
    end else if ((r_state == ST_IDLE) && req) begin
      r_pc <= pc;
    end
  end

  // One trace line per committed store.
  always_ff @(posedge clk) begin
    if (w_store) begin
      $display("%d@%h: *%h <= %h", $time, w_cur_pc, {w_cur_addr[31:2], 2'b00}, w_merged);
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{pc, w_cur_addr[31:ADDR_W], w_be};
`endif

endmodule

// File: tb/tb_dm_be.sv
// Scoreboard bench for dm_be: WAIT_CYC=0 (u0) and WAIT_CYC=2 (u2) side by side, ADDR_W=6.
module tb_dm_be;
  import dm_pkg::*;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    logic        chk;
    int          lat;
  } res_t;

  logic clk, reset, req0, req2, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, din, pc;
  logic rdy0, e0, b0, rdy2, e2, b2;
  logic [31:0] d0, d2;

  int vec = 0;
  int bad = 0;
  res_t exp_q[$];
  res_t obs0_q[$];
  res_t obs2_q[$];

  dm_be #(.ADDR_W(6), .WAIT_CYC(0)) u0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .size(size), .sext(sext),
    .addr(addr), .din(din), .pc(pc), .ready(rdy0), .dout(d0), .align_err(e0), .busy(b0));
  dm_be #(.ADDR_W(6), .WAIT_CYC(2)) u2 (
    .clk(clk), .reset(reset), .req(req2), .we(we), .size(size), .sext(sext),
    .addr(addr), .din(din), .pc(pc), .ready(rdy2), .dout(d2), .align_err(e2), .busy(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push the expectation, issue one request to both DUTs, collect what each returns.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] d, input logic chk, input logic [31:0] ed, input logic ee);
    res_t r;
    bit g0, g2;
    int n;
    r.dout = ed; r.err = ee; r.chk = chk; r.lat = 0;
    exp_q.push_back(r);
    @(negedge clk);
    we = w; size = sz; sext = sx; addr = a; din = d; pc = pc + 32'd4;
    req0 = 1'b1; req2 = 1'b1;
    @(negedge clk);
    req0 = 1'b0; req2 = 1'b0;
    we = ~w; addr = $urandom(); din = $urandom(); size = 2'($urandom_range(3, 0)); sext = ~sx;
    g0 = 1'b0; g2 = 1'b0; n = 1;
    while (!(g0 && g2) && n <= 12) begin
      if (!g0 && rdy0) begin r.dout = d0; r.err = e0; r.lat = n; obs0_q.push_back(r); g0 = 1'b1; end
      if (!g2 && rdy2) begin r.dout = d2; r.err = e2; r.lat = n; obs2_q.push_back(r); g2 = 1'b1; end
      if (!(g0 && g2)) begin @(negedge clk); n++; end
    end
    if (!g0) begin r.dout = 32'h0; r.err = 1'b0; r.lat = -1; obs0_q.push_back(r); end
    if (!g2) begin r.dout = 32'h0; r.err = 1'b0; r.lat = -1; obs2_q.push_back(r); end
  endtask

  task automatic test_reset();
    int nb0, nb2;
    bit spur;
    res_t e, o0, o2;
    reset = 1'b1; req0 = 1'b1; req2 = 1'b1; we = 1'b1; size = SZ_W; sext = 1'b0;
    addr = 32'h3C; din = 32'hDEADBEEF; pc = 32'h0040_0000;
    repeat (2) @(negedge clk);
    vec++;
    if ({rdy0, e0, b0, d0} !== {1'b0, 1'b0, 1'b1, 32'h0} || {rdy2, e2, b2, d2} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL reset_state: u0 rdy/err/busy/dout=%b%b%b/%h u2=%b%b%b/%h need 001/00000000",
               rdy0, e0, b0, d0, rdy2, e2, b2, d2);
    end
    reset = 1'b0;
    nb0 = 0; nb2 = 0; spur = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (b0) nb0++;
      if (b2) nb2++;
      if (rdy0 || rdy2) spur = 1'b1;
      if (!b0 || !b2) begin req0 = 1'b0; req2 = 1'b0; end
      @(negedge clk);
    end
    vec++;
    if (nb0 !== 16 || nb2 !== 16) begin
      bad++; $display("FAIL clear_busy: busy cycles u0=%0d u2=%0d need 16", nb0, nb2);
    end
    vec++;
    if (spur !== 1'b0) begin bad++; $display("FAIL clear_req_ignored: ready seen=%b need 0", spur); end
    issue(1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, 1'b1, 32'h0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o2 = obs2_q.pop_front();
      vec++;
      if (o0.lat !== 1 || o2.lat !== 3) begin bad++; $display("FAIL rst_lat: got %0d/%0d need 1/3", o0.lat, o2.lat); end
      else if (o0.err !== e.err || o2.err !== e.err) begin bad++; $display("FAIL rst_err: got %b/%b need %b", o0.err, o2.err, e.err); end
      else if (e.chk && (o0.dout !== e.dout || o2.dout !== e.dout)) begin bad++; $display("FAIL rst_dout: got %h/%h need %h", o0.dout, o2.dout, e.dout); end
    end
  endtask

  task automatic test_extend();
    res_t e, o0, o2;
    int k = 0;
    issue(1'b1, SZ_W, 1'b0, 32'h08, 32'h8899AABB, 1'b0, 32'h0, 1'b0);
    issue(1'b0, SZ_B, 1'b1, 32'h09, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0);
    issue(1'b0, SZ_B, 1'b0, 32'h09, 32'h0, 1'b1, 32'h000000AA, 1'b0);
    issue(1'b0, SZ_H, 1'b1, 32'h0A, 32'h0, 1'b1, 32'hFFFF8899, 1'b0);
    issue(1'b0, SZ_H, 1'b0, 32'h0A, 32'h0, 1'b1, 32'h00008899, 1'b0);
    issue(1'b0, SZ_H, 1'b1, 32'h08, 32'h0, 1'b1, 32'hFFFFAABB, 1'b0);
    issue(1'b0, SZ_B, 1'b1, 32'h0B, 32'h0, 1'b1, 32'hFFFFFF88, 1'b0);
    issue(1'b0, SZ_B, 1'b0, 32'h08, 32'h0, 1'b1, 32'h000000BB, 1'b0);
    issue(1'b0, SZ_W, 1'b1, 32'h08, 32'h0, 1'b1, 32'h8899AABB, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o2 = obs2_q.pop_front();
      vec++; k++;
      if (o0.lat !== 1 || o2.lat !== 3) begin bad++; $display("FAIL ext%0d_lat: got %0d/%0d need 1/3", k, o0.lat, o2.lat); end
      else if (o0.err !== e.err || o2.err !== e.err) begin bad++; $display("FAIL ext%0d_err: got %b/%b need %b", k, o0.err, o2.err, e.err); end
      else if (e.chk && (o0.dout !== e.dout || o2.dout !== e.dout)) begin bad++; $display("FAIL ext%0d_dout: got %h/%h need %h", k, o0.dout, o2.dout, e.dout); end
    end
  endtask

  task automatic test_merge();
    res_t e, o0, o2;
    int k = 0;
    issue(1'b1, SZ_W, 1'b0, 32'h08, 32'h44449955, 1'b0, 32'h0, 1'b0);
    issue(1'b1, SZ_B, 1'b0, 32'h08, 32'hABCDEF11, 1'b0, 32'h0, 1'b0);
    issue(1'b1, SZ_H, 1'b0, 32'h0A, 32'h55552233, 1'b0, 32'h0, 1'b0);
    issue(1'b0, SZ_W, 1'b0, 32'h08, 32'h0, 1'b1, 32'h22339911, 1'b0);
    issue(1'b0, SZ_W, 1'b0, 32'h10000048, 32'h0, 1'b1, 32'h22339911, 1'b0);
    issue(1'b1, SZ_H, 1'b0, 32'h00, 32'h12348001, 1'b0, 32'h0, 1'b0);
    issue(1'b0, SZ_H, 1'b1, 32'h00, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
    issue(1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 1'b1, 32'h00008001, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o2 = obs2_q.pop_front();
      vec++; k++;
      if (o0.lat !== 1 || o2.lat !== 3) begin bad++; $display("FAIL mrg%0d_lat: got %0d/%0d need 1/3", k, o0.lat, o2.lat); end
      else if (o0.err !== e.err || o2.err !== e.err) begin bad++; $display("FAIL mrg%0d_err: got %b/%b need %b", k, o0.err, o2.err, e.err); end
      else if (e.chk && (o0.dout !== e.dout || o2.dout !== e.dout)) begin bad++; $display("FAIL mrg%0d_dout: got %h/%h need %h", k, o0.dout, o2.dout, e.dout); end
    end
  endtask

  task automatic test_align();
    res_t e, o0, o2;
    int k = 0;
    issue(1'b1, SZ_W, 1'b0, 32'h04, 32'h01020304, 1'b0, 32'h0, 1'b0);
    issue(1'b1, SZ_W, 1'b0, 32'h06, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
    issue(1'b0, SZ_W, 1'b0, 32'h04, 32'h0, 1'b1, 32'h01020304, 1'b0);
    issue(1'b0, SZ_H, 1'b1, 32'h05, 32'h0, 1'b1, 32'h01020304, 1'b1);
    issue(1'b0, SZ_RSV, 1'b0, 32'h04, 32'h0, 1'b1, 32'h01020304, 1'b1);
    issue(1'b1, SZ_H, 1'b0, 32'h05, 32'hEEEEEEEE, 1'b0, 32'h0, 1'b1);
    issue(1'b1, SZ_RSV, 1'b0, 32'h04, 32'hDDDDDDDD, 1'b0, 32'h0, 1'b1);
    issue(1'b0, SZ_W, 1'b0, 32'h04, 32'h0, 1'b1, 32'h01020304, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o2 = obs2_q.pop_front();
      vec++; k++;
      if (o0.lat !== 1 || o2.lat !== 3) begin bad++; $display("FAIL aln%0d_lat: got %0d/%0d need 1/3", k, o0.lat, o2.lat); end
      else if (o0.err !== e.err || o2.err !== e.err) begin bad++; $display("FAIL aln%0d_err: got %b/%b need %b", k, o0.err, o2.err, e.err); end
      else if (e.chk && (o0.dout !== e.dout || o2.dout !== e.dout)) begin bad++; $display("FAIL aln%0d_dout: got %h/%h need %h", k, o0.dout, o2.dout, e.dout); end
    end
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    @(negedge clk);
    we = 1'b0; size = SZ_W; sext = 1'b0; addr = 32'h08; req0 = 1'b1; req2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec++;
      if (rdy0 !== ((i % 2) == 0)) begin bad++; $display("FAIL b2b_ready%0d: got %b need %b", i, rdy0, ((i % 2) == 0)); end
      if (rdy0) begin
        cnt++;
        vec++;
        if (d0 !== 32'h22339911) begin bad++; $display("FAIL b2b_dout%0d: got %h need 22339911", i, d0); end
      end
    end
    req0 = 1'b0;
    vec++;
    if (cnt !== 4) begin bad++; $display("FAIL b2b_count: got %0d need 4", cnt); end
  endtask

  task automatic test_hold();
    int n = 0;
    @(negedge clk);
    we = 1'b0; size = SZ_W; sext = 1'b0; addr = 32'h0A; req0 = 1'b0; req2 = 1'b1;
    addr = 32'h08;
    while (n < 10) begin
      @(negedge clk);
      n++;
      vec++;
      if (b2 !== 1'b1) begin bad++; $display("FAIL hold_busy%0d: got %b need 1", n, b2); end
      if (rdy2) break;
    end
    req2 = 1'b0;
    vec++;
    if (n !== 3 || d2 !== 32'h22339911) begin bad++; $display("FAIL hold_latency: got %0d/%h need 3/22339911", n, d2); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vec++;
      if (rdy2 !== 1'b0 || b2 !== 1'b0) begin bad++; $display("FAIL hold_extra%0d: ready/busy=%b%b need 00", i, rdy2, b2); end
    end
  endtask

  task automatic test_reset_mid();
    res_t e, o0, o2;
    int n = 0;
    @(negedge clk);
    we = 1'b1; size = SZ_W; sext = 1'b0; addr = 32'h0C; din = 32'h5; req0 = 1'b1; req2 = 1'b1;
    @(negedge clk);
    req0 = 1'b0; req2 = 1'b0; reset = 1'b1;
    @(negedge clk);
    vec++;
    if ({rdy0, e0, b0, d0} !== {1'b0, 1'b0, 1'b1, 32'h0} || {rdy2, e2, b2, d2} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL midrst_state: u0 rdy/err/busy/dout=%b%b%b/%h u2=%b%b%b/%h need 001/00000000",
               rdy0, e0, b0, d0, rdy2, e2, b2, d2);
    end
    reset = 1'b0;
    while ((b0 || b2) && n < 30) begin
      vec++;
      if (rdy0 || rdy2) begin bad++; $display("FAIL midrst_ready: got %b/%b need 0/0", rdy0, rdy2); end
      @(negedge clk);
      n++;
    end
    vec++;
    if (n !== 16) begin bad++; $display("FAIL midrst_clear_len: got %0d need 16", n); end
    issue(1'b0, SZ_W, 1'b0, 32'h0C, 32'h0, 1'b1, 32'h0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o2 = obs2_q.pop_front();
      vec++;
      if (o0.lat !== 1 || o2.lat !== 3) begin bad++; $display("FAIL midrst_lat: got %0d/%0d need 1/3", o0.lat, o2.lat); end
      else if (o0.err !== e.err || o2.err !== e.err) begin bad++; $display("FAIL midrst_err: got %b/%b need %b", o0.err, o2.err, e.err); end
      else if (e.chk && (o0.dout !== e.dout || o2.dout !== e.dout)) begin bad++; $display("FAIL midrst_dout: got %h/%h need %h", o0.dout, o2.dout, e.dout); end
    end
  endtask

  initial begin
    test_reset();
    test_extend();
    test_merge();
    test_align();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
